// File: rtl/maxnet_feeder.sv
// Upstream sequencer for the Maxnet core: loads epsilon and a1..a4 from
// a word stream, pulses start, waits for finish, returns the result.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_valid/s_ready   input word handshake, s_data = epsilon, a1..a4
//   mx_start          one-cycle start pulse to the core
//   mx_epsilon, mx_a* held operands (negative activations clamped to +0)
//   mx_finish, mx_out core finish level and result
//   r_valid/r_ready   result handshake, r_data = mx_out or 0 on timeout
//   r_timeout         job abandoned after TIMEOUT_CYCLES in WAIT
//   r_clamped         an activation of this job was clamped
module maxnet_feeder #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        mx_start,
  output logic [31:0] mx_epsilon,
  output logic [31:0] mx_a1,
  output logic [31:0] mx_a2,
  output logic [31:0] mx_a3,
  output logic [31:0] mx_a4,
  input  logic        mx_finish,
  input  logic [31:0] mx_out,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [31:0] r_data,
  output logic        r_timeout,
  output logic        r_clamped
);

  typedef enum logic [1:0] {
    LOAD,
    START,
    WAIT,
    RESULT
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [2:0]       idx_q;
  logic             clamp_q;
  logic             finish_q;
  logic [CNT_W-1:0] cnt_q;

  logic             s_fire;
  logic             r_fire;
  logic             last_word;
  logic             edge_seen;
  logic             time_up;
  logic             neg;
  logic [31:0]      act_word;

  assign s_ready   = (state_q == LOAD);
  assign r_valid   = (state_q == RESULT);
  assign s_fire    = s_valid & s_ready;
  assign r_fire    = r_valid & r_ready;
  assign last_word = (idx_q == 3'd4);
  // finish_q resets high so a finish left high by an
  // abandoned core job is never taken as a new edge.
  assign edge_seen = mx_finish & ~finish_q;
  assign time_up   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  // Sign bit set on an activation (including -0) clamps to +0.
  assign neg       = s_data[31] && (idx_q != 3'd0);
  assign act_word  = neg ? 32'h0 : s_data;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:   if (s_fire && last_word) state_d = START;
      START:  state_d = WAIT;
      WAIT:   if (edge_seen || time_up) state_d = RESULT;
      RESULT: if (r_fire) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      idx_q      <= 3'd0;
      clamp_q    <= 1'b0;
      finish_q   <= 1'b1;
      cnt_q      <= '0;
      mx_start   <= 1'b0;
      mx_epsilon <= 32'h0;
      mx_a1      <= 32'h0;
      mx_a2      <= 32'h0;
      mx_a3      <= 32'h0;
      mx_a4      <= 32'h0;
      r_data     <= 32'h0;
      r_timeout  <= 1'b0;
      r_clamped  <= 1'b0;
    end else begin
      state_q  <= state_d;
      finish_q <= mx_finish;
      mx_start <= s_fire && last_word;

      if (s_fire) begin
        idx_q <= last_word ? 3'd0 : idx_q + 3'd1;
        if (idx_q == 3'd0) clamp_q <= 1'b0;
        else if (neg) clamp_q <= 1'b1;
        unique case (1'b1)
          (idx_q == 3'd0): mx_epsilon <= s_data;
          (idx_q == 3'd1): mx_a1 <= act_word;
          (idx_q == 3'd2): mx_a2 <= act_word;
          (idx_q == 3'd3): mx_a3 <= act_word;
          default:         mx_a4 <= act_word;
        endcase
      end

      if (state_q == START) cnt_q <= '0;

      // A finish edge beats a simultaneous timeout.
      if (state_q == WAIT) begin
        if (edge_seen) begin
          r_data    <= mx_out;
          r_timeout <= 1'b0;
          r_clamped <= clamp_q;
        end else if (time_up) begin
          r_data    <= 32'h0;
          r_timeout <= 1'b1;
          r_clamped <= clamp_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_maxnet_feeder.sv
// Directed bench for maxnet_feeder: vector table of full jobs plus
// sequences for stale finish, backpressure, reset and timeout.
module tb_maxnet_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        mx_start;
  logic [31:0] mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4;
  logic        mx_finish;
  logic [31:0] mx_out;
  logic        r_valid;
  logic        r_ready;
  logic [31:0] r_data;
  logic        r_timeout;
  logic        r_clamped;

  logic        t_s_ready;
  logic        t_mx_start;
  logic [31:0] t_eps, t_a1, t_a2, t_a3, t_a4;
  logic        t_r_valid;
  logic [31:0] t_r_data;
  logic        t_r_timeout;
  logic        t_r_clamped;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  maxnet_feeder dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .mx_start(mx_start), .mx_epsilon(mx_epsilon),
    .mx_a1(mx_a1), .mx_a2(mx_a2), .mx_a3(mx_a3), .mx_a4(mx_a4),
    .mx_finish(mx_finish), .mx_out(mx_out),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .r_timeout(r_timeout), .r_clamped(r_clamped)
  );

  maxnet_feeder #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut_t (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(t_s_ready), .s_data(s_data),
    .mx_start(t_mx_start), .mx_epsilon(t_eps),
    .mx_a1(t_a1), .mx_a2(t_a2), .mx_a3(t_a3), .mx_a4(t_a4),
    .mx_finish(mx_finish), .mx_out(mx_out),
    .r_valid(t_r_valid), .r_ready(r_ready), .r_data(t_r_data),
    .r_timeout(t_r_timeout), .r_clamped(t_r_clamped)
  );

  typedef struct {
    logic [159:0] w;
    int           lat;
    logic [31:0]  out;
    logic [159:0] ops;
    logic         clamp;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [159:0] act,
                     input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("s_ready_wait", s_ready, 1);
    step();
    s_valid = 1'b0;
    s_data  = 32'hDEADBEEF;
  endtask

  task automatic send_job(input logic [159:0] w);
    for (int i = 0; i < 5; i++) send(w[159-32*i -: 32]);
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!r_valid && cyc < 200) begin
      step();
      cyc++;
    end
  endtask

  function automatic logic [159:0] ops_now();
    return {mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4};
  endfunction

  task automatic run_vec(input vec_t v, input int k);
    int c;
    send_job(v.w);
    chk($sformatf("v%0d_start", k), mx_start, 1);
    step();
    chk($sformatf("v%0d_start_pulse", k), mx_start, 0);
    chk($sformatf("v%0d_ops", k), ops_now(), v.ops);
    repeat (v.lat - 1) step();
    mx_finish = 1'b1;
    mx_out    = v.out;
    wait_result(c);
    chk($sformatf("v%0d_lat", k), c, 1);
    chk($sformatf("v%0d_data", k), r_data, v.out);
    chk($sformatf("v%0d_tmo", k), r_timeout, 0);
    chk($sformatf("v%0d_clamp", k), r_clamped, v.clamp);
    mx_finish = 1'b0;
    r_ready   = 1'b1;
    step();
    r_ready   = 1'b0;
    chk($sformatf("v%0d_rv_clr", k), r_valid, 0);
    chk($sformatf("v%0d_s_ready", k), s_ready, 1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int c;
    vecs[0] = '{w: {32'h3DCCCCCD, 32'h3F800000, 32'h40000000,
                    32'h40400000, 32'h40800000},
                lat: 20, out: 32'h40800000,
                ops: {32'h3DCCCCCD, 32'h3F800000, 32'h40000000,
                      32'h40400000, 32'h40800000},
                clamp: 1'b0};
    vecs[1] = '{w: {32'h3DCCCCCD, 32'h3F800000, 32'hBF800000,
                    32'h40400000, 32'h80000000},
                lat: 5, out: 32'h3F800000,
                ops: {32'h3DCCCCCD, 32'h3F800000, 32'h00000000,
                      32'h40400000, 32'h00000000},
                clamp: 1'b1};
    vecs[2] = '{w: {32'h00000000, 32'h3F000000, 32'h3F000000,
                    32'h3F000000, 32'h3F000000},
                lat: 2, out: 32'h3F000000,
                ops: {32'h00000000, 32'h3F000000, 32'h3F000000,
                      32'h3F000000, 32'h3F000000},
                clamp: 1'b0};
    vecs[3] = '{w: {32'hBDCCCCCD, 32'hC0000000, 32'h40000000,
                    32'h40400000, 32'h7F7FFFFF},
                lat: 1, out: 32'h12345678,
                ops: {32'hBDCCCCCD, 32'h00000000, 32'h40000000,
                      32'h40400000, 32'h7F7FFFFF},
                clamp: 1'b1};

    rst = 1'b1;
    s_valid = 1'b0;
    s_data = 32'h0;
    mx_finish = 1'b0;
    mx_out = 32'h0;
    r_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_outs", {mx_start, r_valid, r_timeout, r_clamped}, 0);
    chk("rst_ops", ops_now(), 0);
    chk("rst_rdata", r_data, 0);

    for (int k = 0; k < 4; k++) run_vec(vecs[k], k);

    // Finish held high from before the job must not complete it.
    mx_finish = 1'b1;
    mx_out = 32'hAAAAAAAA;
    send_job(vecs[2].w);
    chk("stale_start", mx_start, 1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("stale_idle%0d", i), r_valid, 0);
      step();
    end
    mx_finish = 1'b0;
    step();
    chk("stale_low", r_valid, 0);
    mx_finish = 1'b1;
    mx_out = 32'h55555555;
    wait_result(c);
    chk("stale_lat", c, 1);
    mx_out = 32'h11111111;
    step();
    chk("stale_data", r_data, 32'h55555555);
    mx_finish = 1'b0;
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    chk("stale_done", {r_valid, s_ready}, 2'b01);

    // Gaps mid-load, then a stalled result consumer.
    for (int i = 0; i < 5; i++) begin
      s_data = 32'hFFFFFFFF;
      repeat (i + 1) step();
      send(vecs[1].w[159-32*i -: 32]);
    end
    step();
    chk("bp_ops", ops_now(), vecs[1].ops);
    repeat (2) step();
    mx_finish = 1'b1;
    mx_out = 32'h0BADF00D;
    wait_result(c);
    chk("bp_lat", c, 1);
    mx_finish = 1'b0;
    mx_out = 32'h0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_hold%0d", i),
          {r_valid, s_ready, r_clamped, r_data},
          {1'b1, 1'b0, 1'b1, 32'h0BADF00D});
      step();
    end
    r_ready = 1'b1;
    chk("bp_hs_cycle", s_ready, 0);
    step();
    r_ready = 1'b0;
    chk("bp_after", {r_valid, s_ready}, 2'b01);

    // Reset three cycles into WAIT.
    send_job(vecs[0].w);
    step();
    repeat (3) step();
    chk("mid_no_result", r_valid, 0);
    pulse_rst();
    chk("mid_s_ready", s_ready, 1);
    chk("mid_outs", {mx_start, r_valid, r_timeout, r_clamped}, 0);
    chk("mid_ops", ops_now(), 0);
    chk("mid_rdata", r_data, 0);
    run_vec(vecs[1], 4);

    // Timeout on the 8-cycle instance.
    pulse_rst();
    send_job(vecs[1].w);
    chk("tmo_start", t_mx_start, 1);
    c = 0;
    while (!t_r_valid && c < 50) begin
      step();
      c++;
    end
    chk("tmo_lat", c, 9);
    chk("tmo_data", t_r_data, 0);
    chk("tmo_flag", t_r_timeout, 1);
    chk("tmo_clamp", t_r_clamped, 1);

    // Finish edge on the final WAIT cycle beats the timeout.
    pulse_rst();
    send_job(vecs[0].w);
    repeat (8) step();
    chk("race_pre", t_r_valid, 0);
    mx_finish = 1'b1;
    mx_out = 32'hCAFEF00D;
    step();
    chk("race_valid", t_r_valid, 1);
    chk("race_data", t_r_data, 32'hCAFEF00D);
    chk("race_tmo", t_r_timeout, 0);
    mx_finish = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
